// File: rtl/axi_lite_ctrl_regs.sv
// AXI4-Lite slave register block for an HLS NTT kernel: config word bank,
// run/done handshake with sticky DONE, level interrupt and run-cycle counter.
module axi_lite_ctrl_regs #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_BITS  = 8,
  parameter int NUM_CFG      = 4,
  parameter int NUM_STAT     = 20
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_ADDR_WIDTH-1:0]         AWADDR,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [C_DATA_WIDTH-1:0]         WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]       WSTRB,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [C_ADDR_WIDTH-1:0]         ARADDR,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [C_DATA_WIDTH-1:0]         RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RVALID,
  input  logic                            RREADY,
  output logic [NUM_CFG*C_DATA_WIDTH-1:0] cfg_o,
  output logic                            run_o,
  output logic                            complete_rdy_o,
  input  logic                            done_i,
  input  logic [NUM_STAT-1:0]             stat_i,
  output logic                            irq_o
);

  localparam int          BYTES    = C_DATA_WIDTH / 8;
  localparam int          ADDR_LSB = $clog2(BYTES);
  localparam int          IDX_W    = C_ADDR_BITS - ADDR_LSB;
  localparam int unsigned IDX_CFG0 = 4;
  localparam int unsigned CFG_END  = IDX_CFG0 + NUM_CFG;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [C_DATA_WIDTH-1:0] CYC_ONE = {{(C_DATA_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {ST_IDLE, ST_BUSY} run_state_t;
  run_state_t run_state, run_state_nxt;

  logic                            ready_en;
  logic                            aw_held, w_held;
  logic [IDX_W-1:0]                aw_idx_q;
  logic [C_DATA_WIDTH-1:0]         w_data_q;
  logic [BYTES-1:0]                w_strb_q;
  logic                            bvalid_q, rvalid_q;
  logic [1:0]                      bresp_q, rresp_q;
  logic [C_DATA_WIDTH-1:0]         rdata_q;
  logic                            irq_en_q, complete_rdy_q, done_q;
  logic [C_DATA_WIDTH-1:0]         cycles_q;
  logic [NUM_CFG*C_DATA_WIDTH-1:0] cfg_q;

  logic                    aw_hs, w_hs, ar_hs, wr_fire;
  logic [IDX_W-1:0]        wr_idx;
  logic [31:0]             wr_idx32, rd_idx32;
  logic [C_DATA_WIDTH-1:0] wr_data;
  logic [BYTES-1:0]        wr_strb;
  logic                    wr_ctrl, wr_stat, wr_mapped;
  logic                    start_req, done_ev, w1c;
  logic [C_DATA_WIDTH-1:0] rd_mux;
  logic [1:0]              rd_resp;
  logic                    unused_addr_bits;

  // Only the low C_ADDR_BITS of either address bus take part in decoding.
  assign unused_addr_bits = ^{AWADDR, ARADDR};

  assign AWREADY        = ready_en & ~aw_held & ~bvalid_q;
  assign WREADY         = ready_en & ~w_held & ~bvalid_q;
  assign ARREADY        = ready_en & ~rvalid_q;
  assign BVALID         = bvalid_q;
  assign BRESP          = bresp_q;
  assign RVALID         = rvalid_q;
  assign RDATA          = rdata_q;
  assign RRESP          = rresp_q;
  assign cfg_o          = cfg_q;
  assign run_o          = (run_state == ST_BUSY);
  assign complete_rdy_o = complete_rdy_q;
  assign irq_o          = done_q & irq_en_q;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign ar_hs = ARVALID & ARREADY;

  // The write commits on the edge that completes the second of AW/W, taking
  // whichever half is still on the bus directly rather than from the holding regs.
  assign wr_fire  = (aw_held | aw_hs) & (w_held | w_hs) & ~bvalid_q;
  assign wr_idx   = aw_held ? aw_idx_q : AWADDR[C_ADDR_BITS-1:ADDR_LSB];
  assign wr_data  = w_held ? w_data_q : WDATA;
  assign wr_strb  = w_held ? w_strb_q : WSTRB;
  assign wr_idx32 = 32'(wr_idx);
  assign rd_idx32 = 32'(ARADDR[C_ADDR_BITS-1:ADDR_LSB]);

  always_comb begin
    wr_ctrl   = wr_fire && (wr_idx32 == 32'd0);
    wr_stat   = wr_fire && (wr_idx32 == 32'd1);
    wr_mapped = (wr_idx32 <= 32'd2) || ((wr_idx32 >= IDX_CFG0) && (wr_idx32 < CFG_END));
    start_req = wr_ctrl && wr_strb[0] && wr_data[0] && (run_state == ST_IDLE);
    done_ev   = done_i && (run_state == ST_BUSY);
    w1c       = wr_stat && wr_strb[0] && wr_data[1];
  end

  always_comb begin
    run_state_nxt = run_state;
    case (run_state)
      ST_IDLE: if (start_req) run_state_nxt = ST_BUSY;
      ST_BUSY: if (done_i)    run_state_nxt = ST_IDLE;
      default: run_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_mux  = '0;
    rd_resp = RESP_OKAY;
    if (rd_idx32 == 32'd0) begin
      rd_mux[1] = irq_en_q;
      rd_mux[2] = complete_rdy_q;
    end else if (rd_idx32 == 32'd1) begin
      rd_mux[0]            = (run_state == ST_BUSY);
      rd_mux[1]            = done_q;
      rd_mux[NUM_STAT+1:2] = stat_i;
    end else if (rd_idx32 == 32'd2) begin
      rd_mux = cycles_q;
    end else begin
      rd_resp = RESP_SLVERR;
      for (int unsigned i = 0; i < NUM_CFG; i++) begin
        if (rd_idx32 == IDX_CFG0 + i) begin
          rd_mux  = cfg_q[i*C_DATA_WIDTH +: C_DATA_WIDTH];
          rd_resp = RESP_OKAY;
        end
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ready_en  <= 1'b0;
      run_state <= ST_IDLE;
    end else begin
      ready_en  <= 1'b1;
      run_state <= run_state_nxt;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_idx_q <= AWADDR[C_ADDR_BITS-1:ADDR_LSB];
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && BREADY) begin
        bvalid_q <= 1'b0;
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_mux;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      irq_en_q       <= 1'b0;
      complete_rdy_q <= 1'b0;
      done_q         <= 1'b0;
      cycles_q       <= '0;
    end else begin
      if (wr_ctrl && wr_strb[0]) begin
        irq_en_q       <= wr_data[1];
        complete_rdy_q <= wr_data[2];
      end
      // Completion outranks a same-cycle W1C; start and completion are exclusive.
      if (done_ev) begin
        done_q <= 1'b1;
      end else if (start_req || w1c) begin
        done_q <= 1'b0;
      end
      if (start_req) begin
        cycles_q <= '0;
      end else if ((run_state == ST_BUSY) && (cycles_q != '1)) begin
        cycles_q <= cycles_q + CYC_ONE;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cfg_q <= '0;
    end else if (wr_fire) begin
      for (int unsigned i = 0; i < NUM_CFG; i++) begin
        for (int unsigned b = 0; b < BYTES; b++) begin
          if ((wr_idx32 == IDX_CFG0 + i) && wr_strb[b]) begin
            cfg_q[i*C_DATA_WIDTH + b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_ctrl_regs.sv
// Bench for axi_lite_ctrl_regs: directed scenarios plus randomized traffic
// compared against a register-map level reference model.
module tb_axi_lite_ctrl_regs;
  localparam int AW = 32, DW = 32, AB = 8, NCFG = 4, NSTAT = 20;
  localparam int SB = DW / 8;

  logic ACLK = 1'b0, ARESET = 1'b1;
  logic [AW-1:0] AWADDR = '0, ARADDR = '0;
  logic AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
  logic [DW-1:0] WDATA = '0;
  logic [SB-1:0] WSTRB = '0;
  logic AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0] BRESP, RRESP;
  logic [DW-1:0] RDATA;
  logic [NCFG*DW-1:0] cfg_o;
  logic run_o, complete_rdy_o, irq_o;
  logic done_i = 1'b0;
  logic [NSTAT-1:0] stat_i = '0;

  axi_lite_ctrl_regs #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_ADDR_BITS(AB),
                       .NUM_CFG(NCFG), .NUM_STAT(NSTAT)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .cfg_o(cfg_o), .run_o(run_o), .complete_rdy_o(complete_rdy_o),
    .done_i(done_i), .stat_i(stat_i), .irq_o(irq_o)
  );

  always #5 ACLK = ~ACLK;

  int unsigned cyc_now = 0;
  always @(posedge ACLK) cyc_now <= cyc_now + 1;

  int n_tests = 0, n_fail = 0;

  // Reference model: architectural register contents only.
  logic [DW-1:0] m_cfg [NCFG];
  bit m_irq_en, m_crdy, m_busy, m_done;
  int unsigned m_t_start;
  logic [DW-1:0] m_cycles;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCFG; i++) m_cfg[i] = '0;
    m_irq_en = 0; m_crdy = 0; m_busy = 0; m_done = 0; m_t_start = 0; m_cycles = '0;
  endtask

  task automatic model_write(input int unsigned idx, input logic [DW-1:0] d, input logic [SB-1:0] s,
                             input bit done_now, input int unsigned commit, output logic [1:0] resp);
    bit was_busy;
    was_busy = m_busy;
    resp = 2'b00;
    if (done_now && was_busy) begin
      m_busy = 0; m_done = 1; m_cycles = DW'(commit - m_t_start);
    end
    if (idx == 0) begin
      if (s[0]) begin
        m_irq_en = d[1]; m_crdy = d[2];
        if (d[0] && !was_busy) begin
          m_busy = 1; m_done = 0; m_cycles = '0; m_t_start = commit;
        end
      end
    end else if (idx == 1) begin
      if (s[0] && d[1] && !(done_now && was_busy)) m_done = 0;
    end else if (idx == 2) begin
      resp = 2'b00;
    end else if (idx >= 4 && idx < 4 + NCFG) begin
      for (int b = 0; b < SB; b++)
        if (s[b]) m_cfg[idx-4][b*8 +: 8] = d[b*8 +: 8];
    end else begin
      resp = 2'b10;
    end
  endtask

  task automatic model_read(input int unsigned idx, input int unsigned hs, input logic [NSTAT-1:0] st,
                            output logic [DW-1:0] d, output logic [1:0] resp);
    d = '0; resp = 2'b00;
    if (idx == 0) begin
      d[1] = m_irq_en; d[2] = m_crdy;
    end else if (idx == 1) begin
      d[0] = m_busy; d[1] = m_done; d[NSTAT+1:2] = st;
    end else if (idx == 2) begin
      d = m_busy ? DW'(hs - 1 - m_t_start) : m_cycles;
    end else if (idx >= 4 && idx < 4 + NCFG) begin
      d = m_cfg[idx-4];
    end else begin
      resp = 2'b10;
    end
  endtask

  task automatic check_outs(input string tag);
    check_eq({tag, "_run_o"}, run_o, m_busy);
    check_eq({tag, "_irq_o"}, irq_o, m_done & m_irq_en);
    check_eq({tag, "_crdy_o"}, complete_rdy_o, m_crdy);
    for (int i = 0; i < NCFG; i++) check_eq({tag, "_cfg_o"}, cfg_o[i*DW +: DW], m_cfg[i]);
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [SB-1:0] strb,
                           input int unsigned aw_dly, input int unsigned w_dly, input int unsigned b_hold,
                           input bit pulse_done, output logic [1:0] resp, output int unsigned commit);
    bit aw_done, w_done, aw_go, w_go;
    int unsigned c;
    aw_done = 0; w_done = 0; c = 0; resp = 2'b11;
    while (!(aw_done && w_done) && c < 64) begin
      if (!aw_done && c >= aw_dly) begin AWADDR = addr; AWVALID = 1'b1; end
      if (!w_done && c >= w_dly) begin WDATA = data; WSTRB = strb; WVALID = 1'b1; end
      aw_go = AWVALID && AWREADY;
      w_go  = WVALID && WREADY;
      if (pulse_done && (aw_done || aw_go) && (w_done || w_go)) done_i = 1'b1;
      check_eq("b_early", BVALID, 1'b0);
      @(posedge ACLK); #1;
      done_i = 1'b0;
      if (aw_go) begin aw_done = 1; AWVALID = 1'b0; end
      if (w_go)  begin w_done = 1;  WVALID = 1'b0; end
      c++;
    end
    commit = cyc_now;
    check_eq("aw_w_accept", {aw_done, w_done}, 2'b11);
    AWVALID = 1'b0; WVALID = 1'b0;
    if (!(aw_done && w_done)) return;
    check_eq("b_latency", BVALID, 1'b1);
    for (int i = 0; i < int'(b_hold); i++) begin
      @(posedge ACLK); #1;
      check_eq("b_hold", BVALID, 1'b1);
    end
    resp = BRESP;
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    check_eq("b_drop", BVALID, 1'b0);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int unsigned r_hold,
                          output logic [DW-1:0] data, output logic [1:0] resp, output int unsigned hs);
    bit go;
    int unsigned c;
    go = 0; c = 0;
    ARADDR = addr; ARVALID = 1'b1;
    while (!go && c < 64) begin
      check_eq("r_early", RVALID, 1'b0);
      go = ARREADY;
      @(posedge ACLK); #1;
      c++;
    end
    ARVALID = 1'b0;
    hs = cyc_now;
    check_eq("ar_accept", go, 1'b1);
    check_eq("r_latency", RVALID, 1'b1);
    data = RDATA; resp = RRESP;
    for (int i = 0; i < int'(r_hold); i++) begin
      @(posedge ACLK); #1;
      check_eq("r_stable", {RVALID, RDATA, RRESP}, {1'b1, data, resp});
    end
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    check_eq("r_drop", RVALID, 1'b0);
  endtask

  task automatic write_check(input string tag, input int unsigned idx, input logic [DW-1:0] d,
                             input logic [SB-1:0] s, input int unsigned aw_dly, input int unsigned w_dly,
                             input int unsigned b_hold, input bit pulse, input logic [AW-1:0] hi);
    logic [1:0] r, er;
    int unsigned commit;
    axi_write(hi + AW'(idx * SB), d, s, aw_dly, w_dly, b_hold, pulse, r, commit);
    model_write(idx, d, s, pulse, commit, er);
    check_eq({tag, "_bresp"}, r, er);
    check_outs(tag);
  endtask

  task automatic read_check(input string tag, input int unsigned idx, output logic [DW-1:0] d);
    logic [1:0] r, er;
    logic [DW-1:0] ed;
    int unsigned hs;
    stat_i = NSTAT'($urandom);
    axi_read(AW'(idx * SB), $urandom_range(0, 2), d, r, hs);
    model_read(idx, hs, stat_i, ed, er);
    check_eq({tag, "_rdata"}, d, ed);
    check_eq({tag, "_rresp"}, r, er);
  endtask

  task automatic pulse_done_i();
    done_i = 1'b1;
    @(posedge ACLK); #1;
    done_i = 1'b0;
    if (m_busy) begin m_busy = 0; m_done = 1; m_cycles = DW'(cyc_now - m_t_start); end
  endtask

  task automatic wait_until(input int unsigned target);
    for (int i = 0; i < 1000 && cyc_now < target; i++) begin @(posedge ACLK); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic [1:0] r;
    int unsigned hs, t0;
    model_reset();

    repeat (3) @(posedge ACLK);
    #1;
    check_eq("rst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
    check_eq("rst_valid", {BVALID, RVALID, BRESP, RRESP}, 6'b0);
    check_outs("rst");
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    check_eq("ready_after_rst", {AWREADY, WREADY, ARREADY}, 3'b111);

    // Byte-masked CFG write.
    write_check("cfg1_full", 5, 32'h12345678, 4'hF, 0, 0, 0, 0, '0);
    write_check("cfg1_mask", 5, 32'hDEADBEEF, 4'b0101, 0, 0, 1, 0, '0);
    read_check("cfg1_rd", 5, d);
    check_eq("cfg1_value", d, 32'h12AD56EF);

    // W three cycles ahead of AW, B held off for four cycles.
    write_check("w_first", 6, 32'hA5A5_0F0F, 4'hF, 3, 0, 4, 0, '0);
    repeat (3) begin @(posedge ACLK); #1; check_eq("no_second_b", BVALID, 1'b0); end
    write_check("aw_first", 7, 32'h0BAD_F00D, 4'b1100, 0, 2, 0, 0, '0);

    // Run cycle with done pulse ten cycles after the start commit.
    write_check("start", 0, 32'h3, 4'h1, 0, 0, 0, 0, '0);
    t0 = m_t_start;
    read_check("busy_status", 1, d);
    wait_until(t0 + 9);
    pulse_done_i();
    check_outs("run_end");
    read_check("cycles", 2, d);
    check_eq("cycles_10", d, 32'd10);
    check_eq("irq_set", irq_o, 1'b1);
    write_check("w1c", 1, 32'h2, 4'h1, 0, 0, 0, 0, '0);
    check_eq("irq_clr", irq_o, 1'b0);
    read_check("status_clr", 1, d);

    // Races.
    write_check("start2", 0, 32'h3, 4'h1, 0, 0, 0, 0, '0);
    write_check("start_busy", 0, 32'h3, 4'h1, 1, 0, 0, 0, '0);
    read_check("cycles_running", 2, d);
    write_check("w1c_vs_done", 1, 32'h2, 4'h1, 0, 0, 0, 1, '0);
    check_eq("done_wins", irq_o, 1'b1);
    write_check("start3", 0, 32'h7, 4'h1, 0, 0, 0, 0, '0);
    write_check("start_vs_done", 0, 32'h3, 4'h1, 0, 1, 0, 1, '0);
    check_eq("run_ended", run_o, 1'b0);
    read_check("cycles_race", 2, d);
    pulse_done_i();
    check_outs("done_idle");
    read_check("status_idle", 1, d);
    read_check("cycles_idle", 2, d);

    // Unmapped indices.
    write_check("unm3", 3, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 0, '0);
    write_check("unm_end", 4 + NCFG, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 0, '0);
    write_check("unm_top", (1 << AB) / SB - 1, 32'h1234, 4'hF, 1, 0, 0, 0, '0);
    read_check("unm3_rd", 3, d);
    read_check("unm_end_rd", 4 + NCFG, d);
    for (int i = 0; i < NCFG; i++) read_check("cfg_after_unm", 4 + i, d);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      int unsigned op, idx;
      op = $urandom_range(0, 5);
      case (op)
        0, 1: write_check("rnd_cfg", 4 + $urandom_range(0, NCFG - 1), $urandom, SB'($urandom),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 0,
                          AW'($urandom_range(0, 255)) << AB);
        2: begin idx = $urandom_range(0, 4 + NCFG + 2); read_check("rnd_rd", idx, d); end
        3: begin
          idx = $urandom_range(0, 4 + NCFG + 2);
          write_check("rnd_wr", idx, $urandom, SB'($urandom), $urandom_range(0, 2),
                      $urandom_range(0, 2), 0, $urandom_range(0, 1), '0);
        end
        4: begin pulse_done_i(); check_outs("rnd_done"); end
        default: begin idx = $urandom_range(1, 2); read_check("rnd_stat", idx, d); end
      endcase
    end

    // Reset while running with a read response outstanding.
    write_check("start_rst", 0, 32'h3, 4'h1, 0, 0, 0, 0, '0);
    ARADDR = AW'(2 * SB); ARVALID = 1'b1;
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    check_eq("pend_rvalid", RVALID, 1'b1);
    #2 ARESET = 1'b1;
    #1;
    model_reset();
    check_eq("arst_valid", {BVALID, RVALID, RDATA, RRESP, BRESP}, '0);
    check_eq("arst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
    check_outs("arst");
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    check_outs("post_rst");
    read_check("post_rst_cfg", 5, d);
    read_check("post_rst_status", 1, d);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_lite_ctrl_regs.md
# axi_lite_ctrl_regs

Parametrised AXI4-Lite slave register block that connects the host to an HLS-generated NTT kernel. It exposes a configurable bank of read/write configuration words and a run/done handshake with a sticky completion flag, interrupt and run-cycle counter. It also packs kernel status bits for readback. It accepts AW and W in either order, returns SLVERR on unmapped addresses, and sits between the PS interconnect and the kernel's `ac_sync` and config ports.

## Interface
Parameters:
- `C_ADDR_WIDTH`, 32: AXI address width; only the low `C_ADDR_BITS` are decoded.
- `C_DATA_WIDTH`, 32: 32 or 64; register stride is `C_DATA_WIDTH/8` bytes (`B`).
- `C_ADDR_BITS`, 8: decoded address bits.
- `NUM_CFG`, 4: config words, 1..(2^C_ADDR_BITS/B − 4).
- `NUM_STAT`, 20: kernel status inputs, 1..C_DATA_WIDTH−2.

Ports:
- `ACLK`  in  1  clock.
- `ARESET`  in  1  asynchronous active-high reset.
- `AWADDR`/`AWVALID`/`AWREADY`, `WDATA`/`WSTRB`/`WVALID`/`WREADY`, `BRESP[1:0]`/`BVALID`/`BREADY`, `ARADDR`/`ARVALID`/`ARREADY`, `RDATA`/`RRESP[1:0]`/`RVALID`/`RREADY`: standard AXI4-Lite slave signals, widths from the parameters.
- `cfg_o`  out  NUM_CFG*C_DATA_WIDTH  config words; word i sits at bits [i*C_DATA_WIDTH +: C_DATA_WIDTH].
- `run_o`  out  1  kernel run request, a level.
- `complete_rdy_o`  out  1  host-ready-for-completion, from CTRL[2].
- `done_i`  in  1  kernel completion pulse.
- `stat_i`  in  NUM_STAT  kernel status bits (triosy/lz).
- `irq_o`  out  1  level interrupt.

## Operation
Word index is `addr[C_ADDR_BITS-1:log2 B]`. The register map is:
- **Index 0, CTRL, RW.** Bit 0 is START, which always reads 0. Bit 1 is IRQ_EN. Bit 2 is COMPLETE_RDY.
- **Index 1, STATUS.** Bit 0 is BUSY. Bit 1 is DONE; it is sticky and cleared by writing 1 to bit 1 (W1C). Bits [NUM_STAT+1:2] are `stat_i`. All other bits are RO.
- **Index 2, CYCLES, RO.** Cycle count of the current run, or of the last run once it has finished.
- **Index 3** is reserved.
- **Index 4+i, CFG[i], RW.** Byte-masked by WSTRB.

Unmapped indices behave as follows:
- Writes are ignored and return BRESP=2'b10.
- Reads return 0 with RRESP=2'b10.
- RO registers ignore writes with BRESP=OKAY, except the STATUS W1C bit.

Run control:
- Writing START=1 while idle (with WSTRB[0]=1):
  - BUSY goes to 1 and `run_o` goes to 1.
  - CYCLES clears to 0.
  - DONE clears.
- START=1 while BUSY is ignored.
- While BUSY, CYCLES increments every cycle and saturates at all-ones.
- When `done_i`=1 and BUSY=1, the next cycle has BUSY=0, `run_o`=0, DONE=1, and CYCLES frozen.
- `done_i` while idle is ignored.
- `irq_o` = DONE & IRQ_EN.

Write path:
- AW and W are captured independently into holding registers: AWREADY = !aw_held & !BVALID, and WREADY = !w_held & !BVALID.
- The register update happens in the cycle after both are held, or both handshake in the same cycle. BVALID rises in that same cycle.
- BVALID holds until BREADY. The holding registers clear on the B handshake.

Read path:
- ARREADY = !RVALID.
- On the AR handshake, RDATA/RRESP are registered and RVALID rises the next cycle.
- RDATA holds stable until RREADY.
- Read and write are fully concurrent.

## Timing
- Reset values: all outputs and registers are 0. READY signals become 1 in the first cycle after ARESET deasserts. Reset mid-transaction drops BVALID/RVALID and any held AW/W immediately.
- Write latency: B is returned 1 cycle after the last of AW/W, and the register value is visible in that same cycle.
- Read latency: 1 cycle from AR handshake to RVALID.
- A read handshaking in the same cycle as a write update returns the pre-update value.
- If a `done_i` set and a DONE W1C happen in the same cycle, the set wins.
- If a START write and `done_i` happen in the same cycle while BUSY, `done_i` completes the run and START is ignored.
- CYCLES counts from the cycle after the START write through the `done_i` cycle inclusive.
- STATUS samples `stat_i` at AR handshake. There is no synchroniser; `stat_i` is in the ACLK domain.

## Test plan
- **CFG byte-mask write:** Write CFG[1]=0xDEADBEEF with WSTRB=4'b0101 over 0x12345678 → readback 0x12AD56EF with RRESP=0, and `cfg_o` word 1 matches.
- **W-before-AW:** Send W 3 cycles before AW → single BVALID 1 cycle after AW, with BREADY held low 4 cycles so BVALID is held; no second write occurs.
- **Run cycle:**
  - Write CTRL=0x3 → `run_o`=1 and BUSY=1.
  - Pulse `done_i` 10 cycles later → `run_o`=0, DONE=1, CYCLES=10, `irq_o`=1.
  - Write STATUS=0x2 → DONE=0 and `irq_o`=0.
- **Same-cycle races:**
  - START while BUSY → ignored.
  - `done_i` coincident with DONE W1C → DONE remains 1.
  - `done_i` while idle → no change.
- **Unmapped address:** Write/read index 3 or beyond the CFG bank → BRESP/RRESP=2'b10, RDATA=0, and no register changes.
- **Reset mid-run:** Assert ARESET with BUSY=1 and RVALID pending → all outputs 0 asynchronously; CFG=0 after release.
